// File: rtl/pipe_adder_pkg.sv
// Shared sizing helper and per-stage control struct for pipe_adder.
package pipe_adder_pkg;

    function automatic int seg_w(input int width, input int stages);
        return width / stages;
    endfunction

    typedef struct packed {
        logic carry;
        logic valid;
    } stage_ctl_t;

endpackage

// File: rtl/pipe_adder_seg.sv
// One carry segment of pipe_adder: SEG-bit adder with registered partial sum and carry-out.
module pipe_adder_seg #(
    parameter int SEG = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en_i,
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           c_i,
    output logic [SEG-1:0] s_o,
    output logic           c_o
);
    logic [SEG:0]   sum_d;
    logic [SEG-1:0] s_q;
    logic           c_q;

    assign sum_d = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, c_i};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q <= '0;
            c_q <= 1'b0;
        end else if (en_i) begin
            s_q <= sum_d[SEG-1:0];
            c_q <= sum_d[SEG];
        end
    end

    assign s_o = s_q;
    assign c_o = c_q;
endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor with valid/ready flow control, one register stage per carry segment.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int SEG = seg_w(WIDTH, STAGES);

    if (WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a multiple of STAGES");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Whole pipe moves in lockstep; bubbles are kept rather than squeezed out.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub ^ cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * SEG;

        logic [WIDTH-LO-1:0]    op_a, op_b;
        logic                   cin_k, vin_k;
        logic [SEG-1:0]         s;
        logic                   c;
        logic [(k+1)*SEG-1:0]   acc;
        logic                   v_q;
        stage_ctl_t             ctl;

        if (k == 0) begin : g_head
            assign op_a  = a;
            assign op_b  = b_eff;
            assign cin_k = c0;
            assign vin_k = in_valid;
            assign acc   = s;
        end else begin : g_body
            // Finished lower segments ride along so the whole result lines up at the output.
            logic [LO-1:0] lo_q;
            assign op_a  = g_stg[k-1].g_pend.pa_q;
            assign op_b  = g_stg[k-1].g_pend.pb_q;
            assign cin_k = g_stg[k-1].ctl.carry;
            assign vin_k = g_stg[k-1].ctl.valid;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)        lo_q <= '0;
                else if (advance) lo_q <= g_stg[k-1].acc;
            end
            assign acc = {s, lo_q};
        end

        pipe_adder_seg #(.SEG(SEG)) u_seg (
            .clk   (clk),
            .reset (reset),
            .en_i  (advance),
            .a_i   (op_a[SEG-1:0]),
            .b_i   (op_b[SEG-1:0]),
            .c_i   (cin_k),
            .s_o   (s),
            .c_o   (c)
        );

        always_ff @(posedge clk or posedge reset) begin
            if (reset)        v_q <= 1'b0;
            else if (advance) v_q <= vin_k;
        end

        assign ctl = '{carry: c, valid: v_q};

        if (k < STAGES - 1) begin : g_pend
            logic [WIDTH-LO-SEG-1:0] pa_q, pb_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pa_q <= '0;
                    pb_q <= '0;
                end else if (advance) begin
                    pa_q <= op_a[WIDTH-LO-1:SEG];
                    pb_q <= op_b[WIDTH-LO-1:SEG];
                end
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].ctl.valid;
    assign sum       = {g_stg[STAGES-1].ctl.carry, g_stg[STAGES-1].acc};

`ifdef PIPE_ADDER_OVF_EN
    // Operand sign bits travel with the top segment; overflow when both agree and the result differs.
    logic am_q, bm_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            am_q <= 1'b0;
            bm_q <= 1'b0;
        end else if (advance) begin
            am_q <= g_stg[STAGES-1].op_a[SEG-1];
            bm_q <= g_stg[STAGES-1].op_b[SEG-1];
        end
    end
    assign ovf = out_valid && (am_q == bm_q) && (sum[WIDTH-1] != am_q);
`endif
endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: 8/2 main instance plus 32/4 and 8/1 directed instances.
module tb_pipe_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, in_valid, in_ready, sub, cin, out_valid, out_ready;
    logic [W-1:0] a, b;
    logic [W:0]   sum;
    logic         ovf;

    logic         w_vi, w_ri, w_vo;
    logic [31:0]  w_a, w_b;
    logic [32:0]  w_sum;
    logic         w_ovf;

    logic         o_vi, o_ri, o_vo;
    logic [7:0]   o_a, o_b;
    logic [8:0]   o_sum;
    logic         o_ovf;

    pipe_adder #(.WIDTH(W), .STAGES(2)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    pipe_adder #(.WIDTH(32), .STAGES(4)) u_w32 (
        .clk(clk), .reset(reset), .in_valid(w_vi), .in_ready(w_ri),
        .a(w_a), .b(w_b), .sub(1'b0), .cin(1'b0),
        .out_valid(w_vo), .out_ready(1'b1), .sum(w_sum)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(w_ovf)
`endif
    );

    pipe_adder #(.WIDTH(8), .STAGES(1)) u_s1 (
        .clk(clk), .reset(reset), .in_valid(o_vi), .in_ready(o_ri),
        .a(o_a), .b(o_b), .sub(1'b0), .cin(1'b0),
        .out_valid(o_vo), .out_ready(1'b1), .sum(o_sum)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(o_ovf)
`endif
    );

`ifndef PIPE_ADDER_OVF_EN
    assign ovf   = 1'b0;
    assign w_ovf = 1'b0;
    assign o_ovf = 1'b0;
`endif

    typedef struct packed { logic [W:0] sum; logic ovf; } exp_t;
    exp_t q[$];
    int   errors = 0, checks = 0;
    logic stall_prev = 1'b0;
    logic [W:0] stall_sum = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: a+b+cin or a-b-cin as plain integers; overflow from the signed range.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input logic ci);
        exp_t e;
        int   r, sr;
        if (s) begin
            r  = int'(x) - int'(y) - int'(ci) + (1 << W);
            sr = int'($signed(x)) - int'($signed(y)) - int'(ci);
        end else begin
            r  = int'(x) + int'(y) + int'(ci);
            sr = int'($signed(x)) + int'($signed(y)) + int'(ci);
        end
        e.sum = r[W:0];
        e.ovf = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
        return e;
    endfunction

    // Acceptance side: record the expected result of every accepted beat.
    always @(negedge clk)
        if (!reset && in_valid && in_ready) q.push_back(model(a, b, sub, cin));

    // Monitor: compare each delivered result, and watch stall behaviour.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_hold_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_hold_sum", {55'd0, sum}, {55'd0, stall_sum});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h with empty scoreboard", sum);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_sum", {55'd0, sum}, {55'd0, e.sum});
`ifdef PIPE_ADDER_OVF_EN
                    chk("sb_ovf", {63'd0, ovf}, {63'd0, e.ovf});
`endif
                end
            end
            stall_prev = out_valid && !out_ready;
            if (stall_prev) begin
                stall_sum = sum;
                chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            end
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input logic ci);
        int   n;
        logic ok;
        n = 0;
        a = x; b = y; sub = s; cin = ci; in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: beat %0h/%0h not accepted within 100 cycles", x, y);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic run32(input string nm, input logic [31:0] x, input logic [31:0] y,
                         input logic [32:0] e, input logic eo);
        int n;
        w_a = x; w_b = y; w_vi = 1'b1;
        @(posedge clk); #1;
        w_vi = 1'b0;
        n = 1;
        while (!w_vo && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_lat"}, 64'(n), 64'd4);
        chk({nm, "_sum"}, {31'd0, w_sum}, {31'd0, e});
`ifdef PIPE_ADDER_OVF_EN
        chk({nm, "_ovf"}, {63'd0, w_ovf}, {63'd0, eo});
`else
        if (eo === 1'bx) $display("unused");
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic done;
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        w_vi = 1'b0; w_a = '0; w_b = '0; o_vi = 1'b0; o_a = '0; o_b = '0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", {55'd0, sum}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 05+03 visible STAGES edges after being presented
        send(8'h05, 8'h03, 1'b0, 1'b0);
        chk("lat_early", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        chk("lat_valid", {63'd0, out_valid}, 64'd1);
        chk("lat_sum", {55'd0, sum}, 64'h008);

        send(8'hFF, 8'hFF, 1'b0, 1'b0);
        send(8'h80, 8'h80, 1'b0, 1'b0);
        send(8'hA5, 8'h5A, 1'b0, 1'b0);
        send(8'h05, 8'h03, 1'b1, 1'b0);
        send(8'h03, 8'h05, 1'b1, 1'b0);
        send(8'h05, 8'h03, 1'b1, 1'b1);
        send(8'h7F, 8'h01, 1'b0, 1'b0);
        send(8'h80, 8'h01, 1'b1, 1'b0);
        drain();

        // four back-to-back beats, output stalled 3 cycles after the first result
        fork
            begin
                for (int i = 0; i < 4; i++) send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            end
            begin
                int n;
                n = 0;
                while (!out_valid && n < 20) begin
                    @(posedge clk); #2;
                    n++;
                end
                if (!out_valid) begin
                    checks++;
                    errors++;
                    $display("FAIL stall_wait: out_valid never rose");
                end
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();

        // reset with two beats in flight
        send(8'h11, 8'h22, 1'b0, 1'b0);
        send(8'h33, 8'h44, 1'b0, 1'b0);
        reset = 1'b1;
        q.delete();
        #1;
        chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_mid_sum", {55'd0, sum}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        send(8'h01, 8'h01, 1'b0, 1'b0);
        chk("post_rst_early", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
        chk("post_rst_sum", {55'd0, sum}, 64'h002);
        drain();

        // random traffic with random backpressure and idle gaps
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end else begin
                        send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #2;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // wide instance: carry across all four segments
        run32("w32_carry", 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000, 1'b0);
        run32("w32_posovf", 32'h7FFF_FFFF, 32'h0000_0001, 33'h0_8000_0000, 1'b1);
        run32("w32_negovf", 32'h8000_0000, 32'hFFFF_FFFF, 33'h1_7FFF_FFFF, 1'b1);
        run32("w32_small", 32'h0000_0001, 32'h0000_0001, 33'h0_0000_0002, 1'b0);

        // single-stage instance
        o_a = 8'h05; o_b = 8'h03; o_vi = 1'b1;
        chk("s1_in_ready", {63'd0, o_ri}, 64'd1);
        @(posedge clk); #1;
        o_vi = 1'b0;
        chk("s1_valid", {63'd0, o_vo}, 64'd1);
        chk("s1_sum", {55'd0, o_sum}, 64'h008);
        chk("s1_ovf", {63'd0, o_ovf}, 64'd0);
        @(posedge clk); #1;
        chk("s1_idle", {63'd0, o_vo}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
